// File: rtl/ball_collision_engine.sv
// Per-frame ball collision resolver: probes brick memory at the ball's leading-edge corners,
// then checks the platform and walls. Optional ball-lost detection: BALL_LOST_DETECT_EN.
module ball_collision_engine #(
  parameter int COORD_W   = 10,
  parameter int X_MAX     = 640,
  parameter int Y_MAX     = 480,
  parameter int BALL_SIZE = 4,
  parameter int BRICK_W   = 32,
  parameter int BRICK_H   = 16,
  parameter int PLAT_W    = 48,
  parameter int PLAT_Y    = 460
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COORD_W-1:0] ballx,
  input  logic [COORD_W-1:0] bally,
  input  logic [COORD_W-1:0] platx,
  output logic               mem_rd_req,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  input  logic               mem_rd_valid,
  input  logic [1:0]         mem_health,
  output logic               hit_valid,
  output logic [COORD_W-1:0] hit_x,
  output logic [COORD_W-1:0] hit_y,
  output logic               x_dir,
  output logic               y_dir,
  output logic               busy,
  output logic               done,
  output logic               lost,
  output logic [2:0]         state_dbg
);
  typedef enum logic [2:0] {
    IDLE, PY0, PY1, PX0, PX1, PLAT, UPDATE, DONE
  } state_t;

  localparam int PY1_OFF = (BRICK_W < BALL_SIZE) ? BRICK_W - 1 : BALL_SIZE - 1;
  localparam int PX1_OFF = (BRICK_H < BALL_SIZE) ? BRICK_H - 1 : BALL_SIZE - 1;
  localparam logic [COORD_W-1:0] ONE_C     = COORD_W'(1);
  localparam logic [COORD_W-1:0] BS_C      = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] PY1_OFF_C = COORD_W'(PY1_OFF);
  localparam logic [COORD_W-1:0] PX1_OFF_C = COORD_W'(PX1_OFF);
  localparam logic [COORD_W-1:0] XMAX_C    = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] YMAX_C    = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] XWALL_C   = COORD_W'(X_MAX - BALL_SIZE);
  localparam logic [COORD_W-1:0] YWALL_C   = COORD_W'(Y_MAX - BALL_SIZE);
  localparam logic [COORD_W-1:0] PLATY_C   = COORD_W'(PLAT_Y);
  localparam logic [COORD_W-1:0] PLATW_C   = COORD_W'(PLAT_W);

  state_t             state, state_nx;
  logic               y_hit, x_hit, plat_hit;
  logic [COORD_W-1:0] ye, xe, nx_x, nx_y;
  logic               ye_bad, xe_bad, nx_oor, nx_probe;
  logic               step, probe_hit, x_dir_nx, y_dir_nx;

  // Leading edges; the negative direction at coordinate 0 would wrap, so it is flagged as out of range.
  assign ye     = y_dir ? bally + BS_C : bally - ONE_C;
  assign xe     = x_dir ? ballx + BS_C : ballx - ONE_C;
  assign ye_bad = (!y_dir && bally == '0) || (ye >= YMAX_C);
  assign xe_bad = (!x_dir && ballx == '0) || (xe >= XMAX_C);

  // Read handshake: mem_rd_req/mem_x/mem_y are loaded on entry to a probe state and held until
  // mem_rd_valid is sampled high; mem_rd_valid and mem_health are ignored while mem_rd_req is low.
  assign step      = !mem_rd_req || mem_rd_valid;
  assign probe_hit = mem_rd_req && mem_rd_valid && (mem_health != 2'd0);

  always_comb begin
    nx_x     = mem_x;
    nx_y     = mem_y;
    nx_oor   = 1'b1;
    nx_probe = 1'b1;
    case (state_nx)
      PY0: begin nx_x = ballx;             nx_y = ye;    nx_oor = ye_bad || (nx_x >= XMAX_C); end
      PY1: begin nx_x = ballx + PY1_OFF_C; nx_y = ye;    nx_oor = ye_bad || (nx_x >= XMAX_C); end
      PX0: begin nx_x = xe; nx_y = bally;                nx_oor = xe_bad || (nx_y >= YMAX_C); end
      PX1: begin nx_x = xe; nx_y = bally + PX1_OFF_C;    nx_oor = xe_bad || (nx_y >= YMAX_C); end
      default: nx_probe = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PY0;
      PY0:     if (step) state_nx = probe_hit ? PX0 : PY1;
      PY1:     if (step) state_nx = PX0;
      PX0:     if (step) state_nx = probe_hit ? PLAT : PX1;
      PX1:     if (step) state_nx = PLAT;
      PLAT:    state_nx = UPDATE;
      UPDATE:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef BALL_LOST_DETECT_EN
  logic lost_set;
  logic lost_q;
`endif

  // Walls take priority over platform and brick hits.
  always_comb begin
    x_dir_nx = x_dir;
    y_dir_nx = y_dir;
`ifdef BALL_LOST_DETECT_EN
    lost_set = 1'b0;
`endif
    if (bally == '0) y_dir_nx = 1'b1;
    else if (bally >= YWALL_C) begin
`ifdef BALL_LOST_DETECT_EN
      if (plat_hit) y_dir_nx = 1'b0;
      else          lost_set = 1'b1;
`else
      y_dir_nx = 1'b0;
`endif
    end
    else if (plat_hit) y_dir_nx = 1'b0;
    else if (y_hit)    y_dir_nx = ~y_dir;

    if (ballx == '0)          x_dir_nx = 1'b1;
    else if (ballx >= XWALL_C) x_dir_nx = 1'b0;
    else if (x_hit)            x_dir_nx = ~x_dir;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_rd_req <= 1'b0;
      mem_x      <= '0;
      mem_y      <= '0;
      hit_valid  <= 1'b0;
      hit_x      <= '0;
      hit_y      <= '0;
      x_dir      <= 1'b1;
      y_dir      <= 1'b0;
      y_hit      <= 1'b0;
      x_hit      <= 1'b0;
      plat_hit   <= 1'b0;
    end else begin
      state     <= state_nx;
      hit_valid <= probe_hit;
      if (probe_hit) begin
        hit_x <= mem_x;
        hit_y <= mem_y;
        if (state == PY0 || state == PY1) y_hit <= 1'b1;
        else                              x_hit <= 1'b1;
      end
      if (state_nx != state) begin
        mem_rd_req <= nx_probe && !nx_oor;
        mem_x      <= nx_x;
        mem_y      <= nx_y;
      end
      if (state == PLAT)
        plat_hit <= y_dir && (bally + BS_C == PLATY_C) && (ballx + BS_C > platx) &&
                    (ballx < platx + PLATW_C);
      if (state == UPDATE) begin
        x_dir <= x_dir_nx;
        y_dir <= y_dir_nx;
      end
      if (state == DONE) begin
        y_hit    <= 1'b0;
        x_hit    <= 1'b0;
        plat_hit <= 1'b0;
      end
    end
  end

`ifdef BALL_LOST_DETECT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           lost_q <= 1'b0;
    else if (state == UPDATE && lost_set) lost_q <= 1'b1;
  end
  assign lost = lost_q;
`else
  assign lost = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign state_dbg = state;
endmodule

// File: doc/ball_collision_engine.md
Name: ball_collision_engine

Overview:
Per-frame collision resolver for the ball.
- Probes the brick memory at up to four leading-edge corner points of the ball (two on the vertical axis, two on the horizontal axis), using a req/valid read handshake.
- Checks the platform and the playfield walls.
- Updates the registered travel directions and emits one damage pulse per brick struck.
- Sits between the frame tick, the brick RAM and the ball position counter; generalises the earlier fixed-size collision logic with parametrised geometry, memory wait states and platform handling.

Parameters:
COORD_W, 10, width of all coordinates
X_MAX, 640, playfield width in pixels
Y_MAX, 480, playfield height in pixels
BALL_SIZE, 4, ball edge length in pixels
BRICK_W, 32, brick width; horizontal spacing of the vertical-axis probes
BRICK_H, 16, brick height; vertical spacing of the horizontal-axis probes
PLAT_W, 48, platform width
PLAT_Y, 460, y coordinate of the platform top surface

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  frame pulse; begins one resolve pass
ballx  in  COORD_W  ball left edge; stable while busy
bally  in  COORD_W  ball top edge; stable while busy
platx  in  COORD_W  platform left edge
mem_rd_req  out  1  brick-memory read request
mem_x  out  COORD_W  probe x coordinate
mem_y  out  COORD_W  probe y coordinate
mem_rd_valid  in  1  read data valid
mem_health  in  2  health of the brick at the probe point; 0 means empty
hit_valid  out  1  one-cycle brick damage pulse
hit_x  out  COORD_W  probe x of the hit
hit_y  out  COORD_W  probe y of the hit
x_dir  out  1  1 = moving +x
y_dir  out  1  1 = moving +y (down)
busy  out  1  a pass is in progress
done  out  1  one-cycle pulse; directions are final
lost  out  1  sticky ball-lost flag (optional feature)

Behaviour:
Reset
- Asynchronous. Forces state IDLE and mem_rd_req, hit_valid, done, busy, lost all to 0; mem_x, mem_y, hit_x, hit_y to 0; x_dir=1, y_dir=0.
- Reset mid-pass aborts the pass; mem_rd_req drops immediately and no partial direction update occurs.

Leading edges
- ye = bally+BALL_SIZE if y_dir, else bally-1.
- xe = ballx+BALL_SIZE if x_dir, else ballx-1.
- All arithmetic is COORD_W wide.
- A probe coordinate is out of range if it is >=X_MAX or >=Y_MAX, or if it underflowed (ballx==0 or bally==0 with the negative direction). An out-of-range probe issues no request and counts as a miss; its state lasts 1 cycle.

State machine
- IDLE: busy=0. start moves to PY0. start while busy is ignored.
- PY0: probe (ballx, ye). PY1: probe (ballx+BRICK_W-1 clipped to ballx+BALL_SIZE-1, ye).
- PX0: probe (xe, bally). PX1: probe (xe, bally+BALL_SIZE-1).
- Probe handshake:
  - mem_x, mem_y and mem_rd_req are registered on entry to a probe state and held stable until mem_rd_valid is sampled high.
  - mem_rd_valid arrives no earlier than the cycle after the request; a probe therefore takes at least 2 cycles.
  - On valid with mem_health!=0: set y_hit (PY states) or x_hit (PX states), and pulse hit_valid with hit_x/hit_y = probe point for the next cycle.
  - A hit in PY0 skips PY1; a hit in PX0 skips PX1.
- PLAT (1 cycle): plat_hit = y_dir & (bally+BALL_SIZE==PLAT_Y) & (ballx+BALL_SIZE>platx) & (ballx<platx+PLAT_W).
- UPDATE (1 cycle); directions load at the exit edge. Priority is wall first, then hit.
  - y: bally==0 gives y_dir=1; else bally>=Y_MAX-BALL_SIZE gives y_dir=0; else plat_hit gives y_dir=0; else y_hit toggles y_dir.
  - x: ballx==0 gives x_dir=1; else ballx>=X_MAX-BALL_SIZE gives x_dir=0; else x_hit toggles x_dir.
- DONE (1 cycle): done=1, then IDLE. The hit flags clear on the transition to IDLE.

Latency
- Start sampled at edge 0, single-wait memory, no hits: done high in cycle 11.
- Each skipped probe removes 2 cycles.

Optional Feature:
Macro: BALL_LOST_DETECT_EN
- Defined: the bottom wall does not reflect. At bally>=Y_MAX-BALL_SIZE without plat_hit, y_dir is left unchanged and lost sets to 1. lost is sticky until reset.
- Undefined: the bottom wall reflects (y_dir=0) and lost is tied to 0.

Test Plan:
1. Reset mid-pass while mem_rd_req=1 -> mem_rd_req=0 same cycle; x_dir=1, y_dir=0, busy=0; the next start runs a full pass.
2. ball (100,100), y_dir=0, all mem_health=0, memory answers 1 cycle after req -> mem_y=99 on PY0; done in cycle 11; directions unchanged; hit_valid never high.
3. ball (100,100), health=2 at the PY0 point (100,99) -> hit_valid pulses with hit=(100,99); PY1 skipped; y_dir becomes 1; done in cycle 9.
4. ball (636,200), x_dir=1, health=1 at the PX point -> wall has priority: x_dir=0, not toggled to 1; no request issued for x=640 (out of range).
5. y_dir=1, bally=456, ballx=110, platx=100 -> plat_hit, y_dir=0. Repeat with platx=200: macro undefined -> y_dir stays 1 (bally < 476); at bally=476 y_dir=0; macro defined -> lost=1 and y_dir stays 1.
6. Memory stalls mem_rd_valid for 5 cycles -> mem_x/mem_y/mem_rd_req stable throughout; start pulses during the stall are ignored; done arrives 4 cycles later than case 2.
